snake_head_mover: RTL and testbench

Consumer of the one-hot `direction` bus produced by the button-input stage. Latches the requested heading, rejects 180° reversals and malformed codes, and advances the snake head one grid cell per game tick from an internal clock-divider. Outputs the head coordinate, the committed heading and a one-cycle `step` strobe for the body/render logic downstream. Flags a wall crash, or wraps at the walls when built with wrap-around.

---
 rtl/snake_head_mover.sv | 136 +++++++++++++
 tb/tb_snake_head_mover.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/snake_head_mover.sv
// Snake head mover: latches one-hot heading requests, steps the head one cell per tick.
// Build macro SNAKE_WRAP_EN selects wrap-around at the walls instead of a crash.
module snake_head_mover #(
  parameter int unsigned GRID_W   = 40,
  parameter int unsigned GRID_H   = 30,
  parameter int unsigned TICK_DIV = 5_000_000,
  parameter int unsigned START_X  = 20,
  parameter int unsigned START_Y  = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  direction,
  input  logic                        enable,
  output logic [$clog2(GRID_W)-1:0]   head_x,
  output logic [$clog2(GRID_H)-1:0]   head_y,
  output logic [3:0]                  heading,
  output logic                        step,
  output logic                        crash
);

  localparam int unsigned XW = $clog2(GRID_W);
  localparam int unsigned YW = $clog2(GRID_H);
  localparam int unsigned CW = $clog2(TICK_DIV);
`ifdef SNAKE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [3:0] DIR_L = 4'b0001;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_U = 4'b0100;
  localparam logic [3:0] DIR_D = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_pend;
  logic [3:0]      r_heading;
  logic [XW-1:0]   r_head_x;
  logic [YW-1:0]   r_head_y;
  logic            r_step;
  logic            r_crash;

  logic            w_run_en;
  logic            w_tick;
  logic            w_pend_ld;
  logic [3:0]      w_opp;
  logic            w_wall;
  logic            w_move;
  logic            w_crash_evt;
  logic [XW-1:0]   w_x_mv;
  logic [YW-1:0]   w_y_mv;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; DEAD only exits through reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (w_crash_evt) w_state_nxt = S_DEAD;
      S_DEAD:  w_state_nxt = S_DEAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tick, heading filter and move/wall decode
  always_comb begin
    w_run_en  = (r_state == S_RUN) && enable;
    w_tick    = w_run_en && (r_cnt == CW'(TICK_DIV - 1));
    w_opp     = {r_heading[2], r_heading[3], r_heading[0], r_heading[1]};
    w_pend_ld = enable && (r_state != S_DEAD) && $onehot(direction)
                && (direction != r_heading) && (direction != w_opp);
    w_wall    = 1'b0;
    w_x_mv    = r_head_x;
    w_y_mv    = r_head_y;
    case (r_pend)
      DIR_L: begin
        w_wall = (r_head_x == '0);
        w_x_mv = w_wall ? XW'(GRID_W - 1) : r_head_x - XW'(1);
      end
      DIR_R: begin
        w_wall = (r_head_x == XW'(GRID_W - 1));
        w_x_mv = w_wall ? '0 : r_head_x + XW'(1);
      end
      DIR_U: begin
        w_wall = (r_head_y == '0);
        w_y_mv = w_wall ? YW'(GRID_H - 1) : r_head_y - YW'(1);
      end
      DIR_D: begin
        w_wall = (r_head_y == YW'(GRID_H - 1));
        w_y_mv = w_wall ? '0 : r_head_y + YW'(1);
      end
      default: w_wall = 1'b0;
    endcase
    w_move      = w_tick && (WRAP_EN || !w_wall);
    w_crash_evt = w_tick && w_wall && !WRAP_EN;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_pend    <= DIR_R;
      r_heading <= DIR_R;
      r_head_x  <= XW'(START_X);
      r_head_y  <= YW'(START_Y);
      r_step    <= 1'b0;
      r_crash   <= 1'b0;
    end else begin
      r_step  <= w_move;
      r_crash <= r_crash | w_crash_evt;
      if (w_run_en) r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_pend_ld) r_pend <= direction;
      if (w_move) begin
        r_heading <= r_pend;
        r_head_x  <= w_x_mv;
        r_head_y  <= w_y_mv;
      end
    end
  end

  assign head_x  = r_head_x;
  assign head_y  = r_head_y;
  assign heading = r_heading;
  assign step    = r_step;
  assign crash   = r_crash;

endmodule

// File: tb/tb_snake_head_mover.sv
// Directed bench for snake_head_mover on an 8x8 grid, 4-cycle tick, start 4,4.
module tb_snake_head_mover;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] direction;
  logic       enable;
  logic [2:0] head_x;
  logic [2:0] head_y;
  logic [3:0] heading;
  logic       step;
  logic       crash;

  int n_chk = 0;
  int n_err = 0;

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  snake_head_mover #(
    .GRID_W(8), .GRID_H(8), .TICK_DIV(4), .START_X(4), .START_Y(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .direction(direction), .enable(enable),
    .head_x(head_x), .head_y(head_y), .heading(heading), .step(step), .crash(crash)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    logic saw;
    saw = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      saw |= step;
    end
    chk(tag, 32'(saw), 0);
  endtask

  // One full tick: three quiet cycles, then the outcome on the fourth edge
  task automatic do_tick(input string tag, input int ex, input int ey, input int eh,
                         input int es, input int ec);
    idle_cycles({tag, "_quiet"}, 3);
    @(posedge clk); #1;
    chk({tag, "_step"}, 32'(step), es);
    chk({tag, "_crash"}, 32'(crash), ec);
    chk({tag, "_x"}, 32'(head_x), ex);
    chk({tag, "_y"}, 32'(head_y), ey);
    chk({tag, "_hd"}, 32'(heading), eh);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; direction = 4'b0000;
    repeat (2) @(posedge clk); #1;
    chk("rst_x", 32'(head_x), 4);
    chk("rst_y", 32'(head_y), 4);
    chk("rst_hd", 32'(heading), 4'b0010);
    chk("rst_step", 32'(step), 0);
    chk("rst_crash", 32'(crash), 0);

    rst_n = 1'b1;
    idle_cycles("idle_no_move", 3);
    chk("idle_x", 32'(head_x), 4);

    // Enter RUN, then steady moves to the right
    enable = 1'b1;
    @(posedge clk); #1;
    do_tick("t1", 5, 4, 4'b0010, 1, 0);
    direction = 4'b0001;
    do_tick("t2_rev", 6, 4, 4'b0010, 1, 0);
    direction = 4'b0011;
    do_tick("t3_multi", 7, 4, 4'b0010, 1, 0);

    // Up accepted, then left rejected as a reversal of committed right
    direction = 4'b0100;
    @(posedge clk); #1;
    chk("ul_q0", 32'(step), 0);
    direction = 4'b0001;
    idle_cycles("ul_quiet", 2);
    @(posedge clk); #1;
    chk("ul_step", 32'(step), 1);
    chk("ul_x", 32'(head_x), 7);
    chk("ul_y", 32'(head_y), 3);
    chk("ul_hd", 32'(heading), 4'b0100);

    // Right off the east wall at x=7
    direction = 4'b0010;
    if (WRAP) do_tick("wall_r", 0, 3, 4'b0010, 1, 0);
    else      do_tick("wall_r", 7, 3, 4'b0100, 0, 1);
    if (!WRAP) begin
      idle_cycles("dead_quiet", 8);
      chk("dead_crash", 32'(crash), 1);
      chk("dead_x", 32'(head_x), 7);
      chk("dead_y", 32'(head_y), 3);
    end

    rst_n = 1'b0;
    #2;
    chk("arst_x", 32'(head_x), 4);
    chk("arst_y", 32'(head_y), 4);
    chk("arst_hd", 32'(heading), 4'b0010);
    chk("arst_crash", 32'(crash), 0);
    direction = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // Pause mid-count: two enabled counts, ten paused cycles, two more to the tick
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    enable = 1'b0;
    idle_cycles("pause_quiet", 10);
    chk("pause_x", 32'(head_x), 4);
    enable = 1'b1;
    @(posedge clk); #1;
    chk("resume_early", 32'(step), 0);
    @(posedge clk); #1;
    chk("resume_step", 32'(step), 1);
    chk("resume_x", 32'(head_x), 5);
    chk("resume_y", 32'(head_y), 4);

    // Up to the north wall
    direction = 4'b0100;
    do_tick("up1", 5, 3, 4'b0100, 1, 0);
    do_tick("up2", 5, 2, 4'b0100, 1, 0);
    do_tick("up3", 5, 1, 4'b0100, 1, 0);
    do_tick("up4", 5, 0, 4'b0100, 1, 0);
    if (WRAP) do_tick("wall_u", 5, 7, 4'b0100, 1, 0);
    else      do_tick("wall_u", 5, 0, 4'b0100, 0, 1);

    // Reset right on the move edge clears everything including step
    rst_n = 1'b0;
    #2;
    chk("rst2_step", 32'(step), 0);
    chk("rst2_crash", 32'(crash), 0);
    chk("rst2_x", 32'(head_x), 4);
    chk("rst2_y", 32'(head_y), 4);
    chk("rst2_hd", 32'(heading), 4'b0010);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles("rst2_idle", 8);
    chk("rst2_idle_x", 32'(head_x), 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
